// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types, funct3 codes and size decode for the load/store unit
package lsu_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_e;

    // Access length in bytes; 0 marks an encoding with no legal access
    // (load 111, any store with funct3[2] set).
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3, input logic write);
        logic [3:0] sz;
        sz = 4'd0;
        if (!(write && funct3[2])) begin
            case (funct3)
                F3_B, F3_BU: sz = 4'd1;
                F3_H, F3_HU: sz = 4'd2;
                F3_W, F3_WU: sz = 4'd4;
                F3_D:        sz = 4'd8;
                default:     sz = 4'd0;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - pipeline request/response and byte-memory port bundle
interface load_store_unit_if;
    import lsu_pkg::*;

    logic            req_valid;
    logic            req_write;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            stall;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;

    logic [XLEN-1:0] mem_addr;
    logic            mem_re;
    logic            mem_we;
    logic [7:0]      mem_wdata;
    logic [7:0]      mem_rdata;

    // The unit itself: initiates memory accesses, serves the pipeline.
    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output stall, resp_valid, resp_rdata, mem_addr, mem_re, mem_we, mem_wdata
    );

    // Pipeline plus memory seen from the outside.
    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  stall, resp_valid, resp_rdata, mem_addr, mem_re, mem_we, mem_wdata
    );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// rtl/load_store_unit_load_extend.sv - sign/zero extension of assembled load data
module load_extend
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] rdata
);

    // Extend from the access width; unknown encodings read as zero.
    always_comb begin
        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{56{data[7]}},  data[7:0]};
            F3_H:    rdata = {{48{data[15]}}, data[15:0]};
            F3_W:    rdata = {{32{data[31]}}, data[31:0]};
            F3_D:    rdata = data;
            F3_BU:   rdata = {56'b0, data[7:0]};
            F3_HU:   rdata = {48'b0, data[15:0]};
            F3_WU:   rdata = {32'b0, data[31:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-serial MEM-stage load/store initiator
module load_store_unit
    import lsu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    load_store_unit_if.master   bus
);

    lsu_state_e      state_q, state_d;
    logic            write_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] asm_q;
    logic [2:0]      cnt_q;

    logic [3:0]      req_size;
    logic [3:0]      cur_size;
    logic            last_byte;
    logic [5:0]      lane_lsb;
    logic [XLEN-1:0] ext_data;

    assign req_size  = size_bytes(bus.req_funct3, bus.req_write);
    assign cur_size  = size_bytes(funct3_q, write_q);
    assign last_byte = (cnt_q == 3'(cur_size - 4'd1));
    assign lane_lsb  = {cnt_q, 3'b000};

    load_extend u_load_extend (
        .data   (asm_q),
        .funct3 (funct3_q),
        .rdata  (ext_data)
    );

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture, byte counter and load-data assembly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            asm_q    <= '0;
            cnt_q    <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_q  <= bus.req_write;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        asm_q    <= '0;
                        cnt_q    <= 3'd0;
                    end
                end
                ACCESS: begin
                    if (!write_q) begin
                        asm_q[lane_lsb +: 8] <= bus.mem_rdata;
                    end
                    if (!last_byte) begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and output decode; memory strobes only exist in ACCESS.
    always_comb begin
        state_d        = state_q;
        bus.stall      = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.mem_addr   = '0;
        bus.mem_re     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_wdata  = 8'h00;
        case (state_q)
            IDLE: begin
                // Gated by reset so every output is low while reset is held.
                bus.stall = bus.req_valid && !reset;
                if (bus.req_valid) begin
                    state_d = (req_size == 4'd0) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                bus.stall    = 1'b1;
                bus.mem_addr = addr_q + XLEN'(cnt_q);
                bus.mem_re   = !write_q;
                bus.mem_we   = write_q;
                if (write_q) begin
                    bus.mem_wdata = wdata_q[lane_lsb +: 8];
                end
                if (last_byte) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = write_q ? '0 : ext_data;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    load_store_unit_if ifc ();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    logic [7:0] mem [0:31];

    assign ifc.mem_rdata = mem[ifc.mem_addr[4:0]];

    always @(posedge clk) begin
        if (ifc.mem_we) mem[ifc.mem_addr[4:0]] <= ifc.mem_wdata;
    end

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_resp_q [$];
    logic [63:0] exp_rd_q [$];
    logic [71:0] exp_wr_q [$];

    logic [63:0] mon_resp;
    logic [63:0] mon_rd;
    logic [71:0] mon_wr;

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert (!(ifc.mem_re && ifc.mem_we)) else begin
                errors++;
                $error("FAIL strobe_excl observed re=%0b we=%0b expected not both", ifc.mem_re, ifc.mem_we);
            end
            if (!ifc.mem_re && !ifc.mem_we) begin
                checks++;
                assert (ifc.mem_addr === 64'h0 && ifc.mem_wdata === 8'h00) else begin
                    errors++;
                    $error("FAIL idle_mem_bus observed addr=%h wdata=%h expected 0", ifc.mem_addr, ifc.mem_wdata);
                end
            end
            if (ifc.mem_we) begin
                checks++;
                assert (exp_wr_q.size() != 0) else begin
                    errors++;
                    $error("FAIL mem_write_extra observed addr=%h data=%h expected none", ifc.mem_addr, ifc.mem_wdata);
                end
                if (exp_wr_q.size() != 0) begin
                    mon_wr = exp_wr_q.pop_front();
                    checks++;
                    assert ({ifc.mem_addr, ifc.mem_wdata} === mon_wr) else begin
                        errors++;
                        $error("FAIL mem_write observed %h/%h expected %h/%h", ifc.mem_addr, ifc.mem_wdata, mon_wr[71:8], mon_wr[7:0]);
                    end
                end
            end
            if (ifc.mem_re) begin
                checks++;
                assert (exp_rd_q.size() != 0) else begin
                    errors++;
                    $error("FAIL mem_read_extra observed addr=%h expected none", ifc.mem_addr);
                end
                if (exp_rd_q.size() != 0) begin
                    mon_rd = exp_rd_q.pop_front();
                    checks++;
                    assert (ifc.mem_addr === mon_rd) else begin
                        errors++;
                        $error("FAIL mem_read_addr observed %h expected %h", ifc.mem_addr, mon_rd);
                    end
                end
            end
            if (ifc.resp_valid) begin
                checks++;
                assert (exp_resp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL resp_extra observed rdata=%h expected no response", ifc.resp_rdata);
                end
                if (exp_resp_q.size() != 0) begin
                    mon_resp = exp_resp_q.pop_front();
                    checks++;
                    assert (ifc.resp_rdata === mon_resp) else begin
                        errors++;
                        $error("FAIL resp_rdata observed %h expected %h", ifc.resp_rdata, mon_resp);
                    end
                end
            end
        end
    end

    // Drives one request starting just after a rising edge and checks stall and
    // resp_valid in each of its n+2 cycles; data is checked by the monitor.
    task automatic run_req(input logic w, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input int n, input logic [63:0] exp,
                           input bit hold, input string tag);
        ifc.req_valid  = 1'b1;
        ifc.req_write  = w;
        ifc.req_funct3 = f3;
        ifc.req_addr   = a;
        ifc.req_wdata  = wd;
        exp_resp_q.push_back(exp);
        for (int i = 0; i < n; i++) begin
            if (w) exp_wr_q.push_back({a + 64'(i), wd[8*i +: 8]});
            else   exp_rd_q.push_back(a + 64'(i));
        end
        for (int c = 1; c <= n + 2; c++) begin
            @(negedge clk);
            checks++;
            assert (ifc.stall === (c <= n + 1)) else begin
                errors++;
                $error("FAIL %s_stall_c%0d observed %0b expected %0b", tag, c, ifc.stall, (c <= n + 1));
            end
            checks++;
            assert (ifc.resp_valid === (c == n + 2)) else begin
                errors++;
                $error("FAIL %s_resp_valid_c%0d observed %0b expected %0b", tag, c, ifc.resp_valid, (c == n + 2));
            end
            @(posedge clk);
            #1;
            if (!hold) ifc.req_valid = 1'b0;
        end
    endtask

    initial begin
        ifc.req_valid  = 1'b0;
        ifc.req_write  = 1'b0;
        ifc.req_funct3 = 3'b000;
        ifc.req_addr   = 64'h0;
        ifc.req_wdata  = 64'h0;

        #1;
        checks++;
        assert ({ifc.stall, ifc.resp_valid, ifc.resp_rdata, ifc.mem_addr, ifc.mem_re, ifc.mem_we, ifc.mem_wdata} === '0) else begin
            errors++;
            $error("FAIL reset_outputs observed stall=%0b resp=%0b re=%0b we=%0b expected all 0", ifc.stall, ifc.resp_valid, ifc.mem_re, ifc.mem_we);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_req(1'b1, 3'b011, 64'd8, 64'h1122334455667788, 8, 64'h0, 1'b0, "sd");
        run_req(1'b0, 3'b000, 64'd8, 64'h0, 1, 64'hFFFFFFFFFFFFFF88, 1'b0, "lb");
        run_req(1'b0, 3'b100, 64'd8, 64'h0, 1, 64'h0000000000000088, 1'b0, "lbu");
        run_req(1'b1, 3'b010, 64'd3, 64'h0000000084030201, 4, 64'h0, 1'b0, "sw");
        run_req(1'b0, 3'b010, 64'd3, 64'h0, 4, 64'hFFFFFFFF84030201, 1'b0, "lw");
        run_req(1'b0, 3'b110, 64'd3, 64'h0, 4, 64'h0000000084030201, 1'b0, "lwu");
        run_req(1'b1, 3'b001, 64'hFFFFFFFFFFFFFFFF, 64'h00000000000080A5, 2, 64'h0, 1'b0, "sh_wrap");
        run_req(1'b0, 3'b001, 64'hFFFFFFFFFFFFFFFF, 64'h0, 2, 64'hFFFFFFFFFFFF80A5, 1'b0, "lh_wrap");
        run_req(1'b0, 3'b101, 64'hFFFFFFFFFFFFFFFF, 64'h0, 2, 64'h00000000000080A5, 1'b0, "lhu_wrap");
        run_req(1'b0, 3'b111, 64'd8, 64'h0, 0, 64'h0, 1'b0, "load_bad");
        run_req(1'b1, 3'b100, 64'd8, 64'hDEADBEEFDEADBEEF, 0, 64'h0, 1'b0, "store_bad");

        // Store of 8 bytes cut by reset in its third ACCESS cycle: two bytes land.
        ifc.req_valid  = 1'b1;
        ifc.req_write  = 1'b1;
        ifc.req_funct3 = 3'b011;
        ifc.req_addr   = 64'd16;
        ifc.req_wdata  = 64'hA1A2A3A4A5A6A7A8;
        exp_wr_q.push_back({64'd16, 8'hA8});
        exp_wr_q.push_back({64'd17, 8'hA7});
        @(posedge clk);
        #1;
        ifc.req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        assert (ifc.mem_we === 1'b1 && ifc.mem_addr === 64'd18) else begin
            errors++;
            $error("FAIL abort_pre observed we=%0b addr=%h expected 1/%h", ifc.mem_we, ifc.mem_addr, 64'd18);
        end
        reset = 1'b1;
        #1;
        checks++;
        assert ({ifc.stall, ifc.resp_valid, ifc.resp_rdata, ifc.mem_addr, ifc.mem_re, ifc.mem_we, ifc.mem_wdata} === '0) else begin
            errors++;
            $error("FAIL abort_outputs observed stall=%0b resp=%0b we=%0b addr=%h expected all 0", ifc.stall, ifc.resp_valid, ifc.mem_we, ifc.mem_addr);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            assert (ifc.resp_valid === 1'b0 && ifc.stall === 1'b0) else begin
                errors++;
                $error("FAIL abort_quiet observed resp=%0b stall=%0b expected 0/0", ifc.resp_valid, ifc.stall);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        assert (exp_wr_q.size() == 0) else begin
            errors++;
            $error("FAIL abort_writes observed %0d pending expected 0", exp_wr_q.size());
        end

        run_req(1'b0, 3'b011, 64'd8, 64'h0, 8, 64'h1122334455667788, 1'b0, "ld_after_reset");

        run_req(1'b0, 3'b011, 64'd8, 64'h0, 8, 64'h1122334455667788, 1'b1, "ld_b2b_first");
        run_req(1'b0, 3'b011, 64'd8, 64'h0, 8, 64'h1122334455667788, 1'b0, "ld_b2b_second");

        repeat (2) @(posedge clk);
        #1;
        checks++;
        assert (exp_resp_q.size() == 0 && exp_rd_q.size() == 0 && exp_wr_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed resp=%0d rd=%0d wr=%0d expected 0/0/0", exp_resp_q.size(), exp_rd_q.size(), exp_wr_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator for the MEM stage of the 64-bit RISC-V pipeline. It converts one sized load or store (byte, half, word, double) into a byte-serial sequence on an 8-bit-wide port of the byte-addressed little-endian data memory. It stalls the pipeline for the duration of the access and returns sign- or zero-extended load data. Misaligned addresses are legal and are handled the same way as aligned ones.

## Interface
- XLEN, 64, data and address width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; all state and outputs clear immediately
- req_valid  in  1  MEM stage presents an access
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 of the load/store
- req_addr  in  XLEN  byte address of the lowest byte
- req_wdata  in  XLEN  store data; low bytes are used
- stall  out  1  hold the pipeline
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  XLEN  extended load data, valid with resp_valid; 0 for stores
- mem_addr  out  XLEN  byte address to memory
- mem_re  out  1  byte read strobe
- mem_we  out  1  byte write strobe; memory commits on the rising clk edge
- mem_wdata  out  8  byte to write
- mem_rdata  in  8  byte read, combinational from mem_addr in the same cycle

## Operation
- States: IDLE, ACCESS, DONE.
- Sizes by funct3:
  - Loads: 000 LB (1), 001 LH (2), 010 LW (4), 011 LD (8), 100 LBU, 101 LHU, 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD.
- IDLE:
  - If req_valid, latch write, funct3, addr and wdata, and set cnt = 0.
  - Valid funct3 -> ACCESS.
  - Invalid funct3 (load 111; store 1xx) -> DONE directly. No memory strobe is issued and resp_rdata = 0.
- ACCESS, one byte per cycle:
  - mem_addr = addr + cnt, modulo 2^64 (wraps from all-ones to 0).
  - Load: mem_re = 1. mem_rdata is captured into byte lane cnt of the assembly register at the clock edge.
  - Store: mem_we = 1, mem_wdata = wdata byte cnt.
  - If cnt == size-1 -> DONE, else cnt+1.
- DONE:
  - resp_valid = 1.
  - resp_rdata = assembled bytes, sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU/LD) from size*8 bits. It is 0 for stores.
  - Always -> IDLE. req_valid is ignored in DONE.
- stall = (IDLE and req_valid) or ACCESS. It is 0 in DONE, so the pipeline advances on that edge.
- mem_re, mem_we, mem_wdata and mem_addr are 0 outside ACCESS.
- mem_re and mem_we are never both 1.
- Reset mid-access:
  - Return to IDLE, with all outputs 0 asynchronously.
  - Bytes already committed stay in memory (partial store is allowed). No response is produced.

## Timing
- Reset value of every output: 0.
- Access of N bytes:
  - 1 accept cycle + N ACCESS cycles + 1 DONE cycle = N+2 cycles.
  - stall is high for N+1 cycles.
  - resp_valid is asserted in cycle N+2, counted from the first cycle with req_valid.
- Invalid funct3: stall high 1 cycle, resp_valid in cycle 2.
- With req_valid held high continuously, back-to-back requests are accepted in the cycle after DONE. There is no bubble beyond DONE.
- All outputs are decoded from registered state and are glitch-free with respect to request inputs, except stall, which depends combinationally on req_valid in IDLE.

## Structure
- Package lsu_pkg:
  - funct3 localparams.
  - State enum {IDLE, ACCESS, DONE}.
  - Function size_bytes(funct3, write) returning 0 for invalid.
- Sub-module load_extend: combinational; inputs are the 64-bit assembled data and funct3; output is extended resp_rdata.
- Byte counter: 3 bits.

## Test plan
- SD 0x1122334455667788 to addr 8:
  - 8 ACCESS cycles with mem_we at addr 8..15, bytes 88,77,66,55,44,33,22,11.
  - stall high 9 cycles; resp_valid in cycle 10 with resp_rdata 0.
- Memory byte at 8 = 0x88:
  - LB -> 0xFFFFFFFFFFFFFF88.
  - LBU -> 0x0000000000000088.
  - Each completes in 3 cycles.
- Misaligned word, bytes 3..6 = 01,02,03,84:
  - LW addr 3 -> 0xFFFFFFFF84030201.
  - LWU -> 0x0000000084030201.
- LH at 0xFFFFFFFFFFFFFFFF: mem_addr sequence FFFFFFFFFFFFFFFF then 0x0 (wrap); data assembled low byte first.
- Reset mid-SD (asserted during the 3rd ACCESS cycle):
  - All outputs drop to 0 immediately; only 2 bytes are written; no resp_valid.
  - After release, an LD is accepted and completes in 10 cycles.
- Error and back-to-back cases:
  - Load with funct3 111: no mem_re; resp_valid in cycle 2 with resp_rdata 0.
  - Two LDs with req_valid held high: second accepted in the cycle after the first DONE; resp_valid pulses 10 cycles apart.
